// File: rtl/adder_pkg.sv
// Shared definitions for the registered adder and its result collector.
package adder_pkg;

  localparam int unsigned ADD_WIDTH   = 25;
  localparam int unsigned ADD_LATENCY = 2;

  typedef struct packed {
    logic                 overflow;
    logic [ADD_WIDTH-1:0] sum;
  } add_result_t;

  localparam logic [ADD_WIDTH-1:0] ADD_SAT_VALUE = '1;

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through FIFO; head entry is visible whenever count is non-zero.
module result_fifo #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COUNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [COUNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage carries no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + COUNT_W'(push) - COUNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/adder_result_collector.sv
// Handshake front-end and result buffer around the two-cycle registered adder.
// Define OVF_SATURATE_EN to store overflowed results as all-ones sums.
module adder_result_collector
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = ADD_WIDTH,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = ADD_LATENCY,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int unsigned COUNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W   = $clog2(DEPTH + LATENCY + 1);
  localparam int unsigned RES_W   = $bits(add_result_t);

  logic [LATENCY-1:0] vld_pipe;
  logic [COUNT_W-1:0] fifo_count;
  logic [OCC_W-1:0]   occupancy;
  logic [CNT_W-1:0]   ovf_cnt_q;
  logic               accept;
  logic               push;
  logic               pop;
  add_result_t        push_res;
  add_result_t        head_res;
  logic [RES_W-1:0]   head_vec;

  assign add_a = in_a;
  assign add_b = in_b;

  // Credit counts stored plus in-flight results; same-cycle pops are not credited.
  always_comb begin
    occupancy = OCC_W'(fifo_count);
    for (int i = 0; i < int'(LATENCY); i++) begin
      occupancy = occupancy + OCC_W'(vld_pipe[i]);
    end
  end

  assign in_ready = !rst && (occupancy < OCC_W'(DEPTH));
  assign accept   = in_valid && in_ready;

  // Adder has no reset, so only results tagged by the pipeline are captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign push = vld_pipe[LATENCY-1] && !rst;

  always_comb begin
    push_res.overflow = add_overflow;
`ifdef OVF_SATURATE_EN
    push_res.sum = add_overflow ? ADD_SAT_VALUE : ADD_WIDTH'(add_sum);
`else
    push_res.sum = ADD_WIDTH'(add_sum);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else if (push && add_overflow && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
    end
  end

  result_fifo #(
    .DATA_W  (RES_W),
    .DEPTH   (DEPTH),
    .COUNT_W (COUNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_res),
    .pop       (pop),
    .head      (head_vec),
    .count     (fifo_count)
  );

  assign head_res = head_vec;

  // Outputs are held at zero while reset is asserted and whenever the FIFO is empty.
  assign out_valid    = !rst && (fifo_count != '0);
  assign pop          = out_valid && out_ready;
  assign out_sum      = out_valid ? WIDTH'(head_res.sum) : '0;
  assign out_overflow = out_valid && head_res.overflow;
  assign ovf_count    = rst ? '0 : ovf_cnt_q;

endmodule

// File: tb/tb_adder_result_collector.sv
// Scoreboard bench for adder_result_collector with a behavioural two-cycle adder.
module tb_adder_result_collector;

  localparam int unsigned W = 25;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready, in_ready4;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] add_a, add_b, add_a4, add_b4;
  logic [W-1:0] add_sum;
  logic         add_ovf;
  logic         out_valid, out_valid4;
  logic         out_ready;
  logic [W-1:0] out_sum, out_sum4;
  logic         out_overflow, out_overflow4;
  logic [15:0]  ovf_count;
  logic [3:0]   ovf_count4;

  always #5 clk = ~clk;

  adder_result_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_overflow(add_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_overflow(out_overflow),
    .ovf_count(ovf_count)
  );

  adder_result_collector #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .add_a(add_a4), .add_b(add_b4),
    .add_sum(add_sum), .add_overflow(add_ovf), .out_valid(out_valid4),
    .out_ready(out_ready), .out_sum(out_sum4), .out_overflow(out_overflow4),
    .ovf_count(ovf_count4)
  );

  // Unreset two-stage adder; starts with garbage that must never be emitted.
  logic [W:0] s1 = 26'h2A5A5A5;
  logic [W:0] s2 = 26'h3C3C3C3;
  always @(posedge clk) begin
    s1 <= {1'b0, add_a} + {1'b0, add_b};
    s2 <= s1;
  end
  assign add_sum = s2[W-1:0];
  assign add_ovf = s2[W];

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_ovf = 0;
  int   accepts = 0;
  int   pops = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned total;
    total = longint'(a) + longint'(b);
    e.ovf = (total >= (64'd1 << W));
    e.sum = W'(total);
`ifdef OVF_SATURATE_EN
    if (e.ovf) e.sum = '1;
`endif
    return e;
  endfunction

  // Monitor: records accepted operands and checks every popped result in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_ovf = 0;
      chk("reset_outputs", {out_valid, out_overflow, in_ready, out_sum, ovf_count}, '0);
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          chk("unexpected_output", {out_overflow, out_sum}, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("result", {out_overflow, out_sum}, {e.ovf, e.sum});
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_a, in_b);
        sb.push_back(e);
        if (e.ovf) exp_ovf++;
        accepts++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", in_ready, 1);
  endtask

  task automatic check_counts();
    int e4;
    e4 = (exp_ovf > 15) ? 15 : exp_ovf;
    chk("ovf_count", ovf_count, exp_ovf);
    chk("ovf_count_cnt4", ovf_count4, e4);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sb.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", sb.size(), 0);
    check_counts();
  endtask

  task automatic rand_op(input bit force_ovf);
    in_a = W'($urandom);
    in_b = W'($urandom);
    if (force_ovf) begin
      in_a[W-1] = 1'b1;
      in_b[W-1] = 1'b1;
    end
  endtask

  initial begin
    int base_a, base_p;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    do_reset(3);
    check_counts();

    // Single op: visible three cycles after acceptance.
    in_valid = 1'b1; in_a = 25'd100; in_b = 25'd23;
    chk("single_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("single_lat1", out_valid, 0);
    tick();
    chk("single_lat2", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_sum", out_sum, 123);
    chk("single_ovf", out_overflow, 0);
    drain();

    // Overflow edge.
    in_valid = 1'b1; in_a = 25'h1FFFFFF; in_b = 25'd1;
    tick(); in_valid = 1'b0;
    tick(); tick();
`ifdef OVF_SATURATE_EN
    chk("ovf_sum", out_sum, 25'h1FFFFFF);
`else
    chk("ovf_sum", out_sum, 0);
`endif
    chk("ovf_flag", out_overflow, 1);
    drain();
    chk("ovf_count_one", ovf_count, 1);

    // Backpressure: exactly DEPTH accepted, then stall until released.
    out_ready = 1'b0;
    base_a = accepts;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rand_op($urandom_range(0, 1) == 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("bp_accepts", accepts - base_a, 4);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    drain();

    // Streaming: full rate with out_ready held high.
    base_a = accepts;
    base_p = pops;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      rand_op($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = 1'b0;
    chk("stream_accepts", accepts - base_a, 100);
    tick(); tick(); tick();
    chk("stream_pops", pops - base_p, 100);
    drain();

    // Mid-flight reset discards in-flight overflowing results.
    do_reset(2);
    base_p = pops;
    in_valid = 1'b1; rand_op(1'b1);
    tick(); rand_op(1'b1);
    tick(); in_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_out_valid", out_valid, 0);
    end
    chk("midrst_pops", pops - base_p, 0);
    chk("midrst_ovf_count", ovf_count, 0);
    chk("midrst_ovf_count4", ovf_count4, 0);

    // Counter saturation on the narrow-counter instance.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      rand_op(1'b1);
      tick();
    end
    drain();
    chk("sat_ovf4", ovf_count4, 15);
    chk("sat_ovf16", ovf_count, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
